bus_arbiter_mux: RTL and testbench

Parametrised, registered N-source bus multiplexer with built-in round-robin arbitration. It generalises the 2-input/4-bit lab bus selector to WIDTH-bit data and NUM_SRC sources, adds a registered output with a Valid flag, a constant-drive mode, and two sequential modes: request-driven round-robin with a bounded dwell time, and free-running source scan. It sits between the lab's data sources (switch banks, counters, ALU results) and the shared display/register bus.

---
 rtl/bus_arbiter_mux.sv | 122 ++++++++++++
 tb/tb_bus_arbiter_mux.sv | 115 +++++++++++
 2 files changed

// File: rtl/bus_arbiter_mux.sv
// bus_arbiter_mux: registered N-source bus mux with direct, round-robin, constant and auto-scan modes
module bus_arbiter_mux #(
   parameter int WIDTH = 4,
   parameter int NUM_SRC = 4,
   parameter logic [WIDTH-1:0] CONST_VAL = WIDTH'(4'b0011),
   parameter int HOLD = 4,
   localparam int SW = (NUM_SRC > 2) ? $clog2(NUM_SRC) : 1
) (
   input  logic                     i_clock,
   input  logic                     i_reset_n,
   input  logic [1:0]               i_mode,
   input  logic [SW-1:0]            i_sel,
   input  logic [NUM_SRC*WIDTH-1:0] i_inputs,
   input  logic [NUM_SRC-1:0]       i_req,
   output logic [WIDTH-1:0]         o_output,
   output logic                     o_valid,
   output logic [NUM_SRC-1:0]       o_grant,
   output logic [SW-1:0]            o_active_src
);
   typedef enum logic {S_IDLE, S_GRANT} state_t;
   localparam logic [SW:0] NS = (SW+1)'(NUM_SRC);
   localparam logic [7:0] HOLD_M1 = 8'(HOLD-1);
   localparam logic [NUM_SRC-1:0] ONE = NUM_SRC'(1);
   localparam logic [SW-1:0] LAST = SW'(NUM_SRC-1);
   state_t r_state;
   logic [1:0] r_mode;
   logic [SW-1:0] r_ptr;
   logic [7:0] r_cnt;
   logic [WIDTH-1:0] r_output;
   logic r_valid;
   logic [NUM_SRC-1:0] r_grant;
   logic [SW-1:0] r_active_src;
   logic w_idle, w_sel_ok, w_nxt_found, w_slot_end;
   logic [SW:0] w_cand;
   logic [SW-1:0] w_nxt_idx, w_scan_idx;
   logic [7:0] w_scan_cnt;
   assign o_output = r_output;
   assign o_valid = r_valid;
   assign o_grant = r_grant;
   assign o_active_src = r_active_src;
   // A mode change forces the arbiter back to IDLE for the current edge
   assign w_idle = (r_state == S_IDLE) || (i_mode != r_mode);
   assign w_sel_ok = {1'b0, i_sel} < NS;
   assign w_slot_end = r_cnt == HOLD_M1;
   // First requester circularly after the pointer; the pointer itself is the last resort
   always_comb begin
      w_nxt_found = 1'b0;
      w_nxt_idx = r_ptr;
      w_cand = '0;
      for (int j = NUM_SRC-1; j >= 1; j--) begin
         w_cand = {1'b0, r_ptr} + (SW+1)'(j);
         w_cand = (w_cand >= NS) ? w_cand - NS : w_cand;
         if (i_req[w_cand[SW-1:0]]) begin
            w_nxt_found = 1'b1;
            w_nxt_idx = w_cand[SW-1:0];
         end
      end
      if (!w_nxt_found && i_req[r_ptr]) begin
         w_nxt_found = 1'b1;
         w_nxt_idx = r_ptr;
      end
   end
   // Auto-scan slot sequencing: restart at source 0 on entry, advance every HOLD cycles
   always_comb begin
      w_scan_idx = w_idle ? '0 : w_slot_end ? ((r_active_src == LAST) ? '0 : r_active_src + SW'(1)) : r_active_src;
      w_scan_cnt = (w_idle || w_slot_end) ? 8'd0 : r_cnt + 8'd1;
   end
   // Mode datapath and arbiter state machine, all outputs registered
   always_ff @(posedge i_clock) begin
      if (!i_reset_n) begin
         r_state <= S_IDLE;
         r_mode <= 2'b00;
         r_ptr <= LAST;
         r_cnt <= '0;
         r_output <= '0;
         r_valid <= 1'b0;
         r_grant <= '0;
         r_active_src <= '0;
      end else begin
         r_mode <= i_mode;
         if (i_mode == 2'b00) begin
            r_state <= S_IDLE;
            r_cnt <= '0;
            r_grant <= '0;
            r_valid <= w_sel_ok;
            r_active_src <= w_sel_ok ? i_sel : '0;
            r_output <= w_sel_ok ? i_inputs[i_sel*WIDTH +: WIDTH] : '0;
         end else if (i_mode == 2'b10) begin
            r_state <= S_IDLE;
            r_cnt <= '0;
            r_grant <= '0;
            r_valid <= 1'b1;
            r_active_src <= '0;
            r_output <= CONST_VAL;
         end else if (i_mode == 2'b11) begin
            r_state <= S_GRANT;
            r_cnt <= w_scan_cnt;
            r_valid <= 1'b1;
            r_active_src <= w_scan_idx;
            r_grant <= ONE << w_scan_idx;
            r_output <= i_inputs[w_scan_idx*WIDTH +: WIDTH];
         end else if (!w_idle && i_req[r_ptr] && !w_slot_end) begin
            r_cnt <= r_cnt + 8'd1;
            r_output <= i_inputs[r_ptr*WIDTH +: WIDTH];
         end else if (w_nxt_found) begin
            r_state <= S_GRANT;
            r_ptr <= w_nxt_idx;
            r_cnt <= '0;
            r_valid <= 1'b1;
            r_grant <= ONE << w_nxt_idx;
            r_active_src <= w_nxt_idx;
            r_output <= i_inputs[w_nxt_idx*WIDTH +: WIDTH];
         end else begin
            r_state <= S_IDLE;
            r_cnt <= '0;
            r_valid <= 1'b0;
            r_grant <= '0;
            r_active_src <= '0;
         end
      end
   end
endmodule

// File: tb/tb_bus_arbiter_mux.sv
// tb_bus_arbiter_mux: directed self-checking bench for bus_arbiter_mux
module tb_bus_arbiter_mux;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [1:0] mode = 2'b00, mode2 = 2'b00;
   logic [1:0] sel = '0, sel2 = '0;
   logic [15:0] inputs = 16'hDCBA;
   logic [11:0] inputs2 = 12'h321;
   logic [3:0] req = '0;
   logic [2:0] req2 = '0;
   logic [3:0] out, out2, grant;
   logic [2:0] grant2;
   logic valid, valid2;
   logic [1:0] act, act2;
   int n_tests = 0, n_fail = 0;
   always #5 clk = ~clk;
   bus_arbiter_mux #(.WIDTH(4), .NUM_SRC(4), .HOLD(4)) dut (
      .i_clock(clk), .i_reset_n(rst_n), .i_mode(mode), .i_sel(sel), .i_inputs(inputs),
      .i_req(req), .o_output(out), .o_valid(valid), .o_grant(grant), .o_active_src(act));
   bus_arbiter_mux #(.WIDTH(4), .NUM_SRC(3), .HOLD(2)) dut2 (
      .i_clock(clk), .i_reset_n(rst_n), .i_mode(mode2), .i_sel(sel2), .i_inputs(inputs2),
      .i_req(req2), .o_output(out2), .o_valid(valid2), .o_grant(grant2), .o_active_src(act2));
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   initial begin
      tick();
      chk("rst_out", 32'(out), 0);
      chk("rst_valid", 32'(valid), 0);
      chk("rst_grant", 32'(grant), 0);
      chk("rst_act", 32'(act), 0);
      rst_n = 1'b1; mode = 2'b01; req = 4'b0010;
      tick();
      chk("g1_grant", 32'(grant), 32'b0010);
      chk("g1_out", 32'(out), 32'hB);
      rst_n = 1'b0;
      tick();
      chk("mid_rst_out", 32'(out), 0);
      chk("mid_rst_valid", 32'(valid), 0);
      chk("mid_rst_grant", 32'(grant), 0);
      rst_n = 1'b1;
      tick();
      chk("regrant", 32'(grant), 32'b0010);
      chk("regrant_valid", 32'(valid), 1);
      mode = 2'b00; sel = 2'd2;
      tick();
      chk("dir2_out", 32'(out), 32'hC);
      chk("dir2_valid", 32'(valid), 1);
      chk("dir2_grant", 32'(grant), 0);
      chk("dir2_act", 32'(act), 2);
      sel = 2'd3;
      tick();
      chk("dir3_out", 32'(out), 32'hD);
      mode = 2'b10;
      tick();
      chk("const_out", 32'(out), 32'b0011);
      chk("const_valid", 32'(valid), 1);
      chk("const_grant", 32'(grant), 0);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1; mode = 2'b01; req = 4'b1111;
      for (int i = 0; i < 17; i++) begin
         tick();
         chk("rr_grant", 32'(grant), 32'b0001 << ((i / 4) % 4));
         chk("rr_out", 32'(out), 32'hA + (i / 4) % 4);
      end
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1; req = 4'b0101;
      tick();
      chk("er_g0", 32'(grant), 32'b0001);
      tick();
      chk("er_g0b", 32'(grant), 32'b0001);
      req = 4'b0100;
      tick();
      chk("er_g2", 32'(grant), 32'b0100);
      chk("er_valid", 32'(valid), 1);
      chk("er_out", 32'(out), 32'hC);
      req = 4'b0000;
      tick();
      chk("er_idle_valid", 32'(valid), 0);
      chk("er_idle_grant", 32'(grant), 0);
      chk("er_idle_hold", 32'(out), 32'hC);
      req = 4'b0001;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("solo_grant", 32'(grant), 32'b0001);
         chk("solo_valid", 32'(valid), 1);
      end
      mode2 = 2'b00; sel2 = 2'd3;
      tick();
      chk("oob_valid", 32'(valid2), 0);
      chk("oob_out", 32'(out2), 0);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1; mode2 = 2'b11;
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("scan_act", 32'(act2), (i / 2) % 3);
         chk("scan_out", 32'(out2), (i / 2) % 3 + 1);
         chk("scan_grant", 32'(grant2), 32'b001 << ((i / 2) % 3));
         chk("scan_valid", 32'(valid2), 1);
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
